// File: rtl/disp_ctrl.sv
// Multi-channel seven-segment display controller: converts CHANNELS values to
// DIGITS active-low segment codes each, in decimal (double-dabble) or hex mode.
module disp_ctrl #(
  parameter int CHANNELS    = 2,
  parameter int IN_WIDTH    = 6,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*IN_WIDTH-1:0]   in,
  input  logic                           mode,
  input  logic                           blank_lz,
  input  logic                           update,
  output logic [CHANNELS*DIGITS*7-1:0]   hex,
  output logic                           busy,
  output logic [CHANNELS-1:0]            ovf
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int          CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int          RC_W    = $clog2(REFRESH_DIV);
  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] HEX_LIM = 64'd1 << BCD_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                          state_r, state_next_s;
  logic [RC_W-1:0]                 rc_r;
  logic                            tick_s, trig_s, start_s;
  logic                            pending_r;
  logic [CHANNELS*IN_WIDTH-1:0]    snap_in_r;
  logic                            snap_mode_r, snap_blank_r;
  logic [CH_W-1:0]                 ch_r;
  logic [CNT_W-1:0]                cnt_r;
  logic [IN_WIDTH-1:0]             shift_r, cur_val_s;
  logic [BCD_W-1:0]                bcd_r, bcd_adj_s;
  logic                            cur_ovf_r, load_ovf_s;
  logic [63:0]                     val64_s;
  logic [DIGITS*7-1:0]             digits_s;
  logic [CHANNELS*DIGITS*7-1:0]    hex_r;
  logic [CHANNELS-1:0]             ovf_r;
  logic                            busy_r;

  assign tick_s    = (rc_r == RC_W'(REFRESH_DIV - 1));
  assign trig_s    = tick_s | update;
  assign cur_val_s = snap_in_r[ch_r*IN_WIDTH +: IN_WIDTH];
  assign val64_s   = 64'(cur_val_s);

  assign hex  = hex_r;
  assign busy = busy_r;
  assign ovf  = ovf_r;

  // Next-state selection and pass-start detection.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_next_s = ST_LOAD;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (snap_mode_r) state_next_s = ST_STORE;
        else             state_next_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_W'(IN_WIDTH - 1)) state_next_s = ST_STORE;
        else                               state_next_s = ST_SHIFT;
      end
      ST_STORE: begin
        if (ch_r == CH_W'(CHANNELS - 1)) state_next_s = ST_DONE;
        else                             state_next_s = ST_LOAD;
      end
      ST_DONE: begin
        // A trigger landing in DONE folds into the back-to-back pass.
        if (pending_r || trig_s) begin
          state_next_s = ST_LOAD;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Overflow decision for the channel being loaded.
  always_comb begin
    if (snap_mode_r) load_ovf_s = (val64_s >= HEX_LIM);
    else             load_ovf_s = (val64_s > DEC_MAX);
  end

  // Add-3 correction of every BCD nibble before the next shift.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
      else                         bcd_adj_s[4*d +: 4] = bcd_r[4*d +: 4];
    end
  end

  // Segment codes for the current channel, scanned from the top digit down for blanking.
  always_comb begin : digit_gen
    logic       lead;
    logic [3:0] nib;
    digits_s = {(DIGITS*7){1'b0}};
    lead     = 1'b1;
    nib      = 4'h0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (snap_mode_r) nib = val64_s[4*d +: 4];
      else             nib = bcd_r[4*d +: 4];
      if (cur_ovf_r) begin
        digits_s[d*7 +: 7] = 7'h3F;
      end else if (snap_blank_r && lead && (nib == 4'h0) && (d != 0)) begin
        digits_s[d*7 +: 7] = 7'h7F;
      end else begin
        digits_s[d*7 +: 7] = seg7(nib);
        lead               = 1'b0;
      end
    end
  end

  // FSM state, busy flag, refresh counter and pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      rc_r      <= {RC_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (tick_s) rc_r <= {RC_W{1'b0}};
      else        rc_r <= rc_r + RC_W'(1);
      if (state_r == ST_IDLE || state_r == ST_DONE) pending_r <= 1'b0;
      else if (trig_s)                              pending_r <= 1'b1;
    end
  end

  // Snapshot capture and per-channel conversion datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_in_r    <= {(CHANNELS*IN_WIDTH){1'b0}};
      snap_mode_r  <= 1'b0;
      snap_blank_r <= 1'b0;
      ch_r         <= {CH_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      shift_r      <= {IN_WIDTH{1'b0}};
      bcd_r        <= {BCD_W{1'b0}};
      cur_ovf_r    <= 1'b0;
      hex_r        <= {(CHANNELS*DIGITS){7'h7F}};
      ovf_r        <= {CHANNELS{1'b0}};
    end else begin
      if (start_s) begin
        snap_in_r    <= in;
        snap_mode_r  <= mode;
        snap_blank_r <= blank_lz;
        ch_r         <= {CH_W{1'b0}};
      end
      case (state_r)
        ST_LOAD: begin
          shift_r   <= cur_val_s;
          bcd_r     <= {BCD_W{1'b0}};
          cnt_r     <= {CNT_W{1'b0}};
          cur_ovf_r <= load_ovf_s;
        end
        ST_SHIFT: begin
          {bcd_r, shift_r} <= {bcd_adj_s[BCD_W-2:0], shift_r, 1'b0};
          cnt_r            <= cnt_r + CNT_W'(1);
          // A digit carried out of the top nibble can only mean an out-of-range value.
          cur_ovf_r        <= cur_ovf_r | bcd_adj_s[BCD_W-1];
        end
        ST_STORE: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (ch_r == CH_W'(k)) begin
              hex_r[k*DIGITS*7 +: DIGITS*7] <= digits_s;
              ovf_r[k]                      <= cur_ovf_r;
            end
          end
          if (ch_r != CH_W'(CHANNELS - 1)) ch_r <= ch_r + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/disp_ctrl.md
Name: disp_ctrl

Overview:
- Parametrised multi-channel seven-segment display controller.
- Replaces the fixed per-value combinational BCD-plus-decoder pairs used to show PC/SP on the board hex displays.
- Converts CHANNELS unsigned values of IN_WIDTH bits to DIGITS digits each, in decimal (sequential double-dabble) or hexadecimal mode.
- Adds optional leading-zero blanking, overflow indication, and periodic or on-demand refresh.

Parameters:
- CHANNELS, 2, number of independent values shown.
- IN_WIDTH, 6, bit width of each input value (>=1).
- DIGITS, 2, digits per channel (1..8).
- REFRESH_DIV, 1_000_000, clk cycles between automatic refresh ticks (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  CHANNELS*IN_WIDTH  packed values; channel k = in[k*IN_WIDTH +: IN_WIDTH].
- mode  input  1  0 = decimal, 1 = hexadecimal.
- blank_lz  input  1  1 = blank leading zero digits.
- update  input  1  single-cycle refresh request.
- hex  output  CHANNELS*DIGITS*7  segment codes; channel k digit d (d=0 least significant) = hex[(k*DIGITS+d)*7 +: 7].
- busy  output  1  conversion pass in progress.
- ovf  output  CHANNELS  per-channel overflow flag.

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: every hex digit = 7'h7F (blank), busy = 0, ovf = 0, refresh counter = 0, pending = 0, FSM = IDLE.
  - Reset asserted mid-pass aborts the pass immediately.
- Segment encoding: active-low, bit0 = a … bit6 = g.
  - Digits 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
  - Dash = 7'h3F. Blank = 7'h7F.
- Refresh counter:
  - Free-running 0..REFRESH_DIV-1, wraps to 0.
  - Tick = counter at REFRESH_DIV-1.
- Trigger = tick OR update.
  - Trigger in IDLE: start a pass next cycle.
  - Trigger while busy: sets pending. Pending starts exactly one new pass directly after the current one; further triggers collapse into it.
- Start of pass (leaving IDLE):
  - in, mode and blank_lz are snapshotted; later changes do not affect the pass.
  - busy = 1 from the first pass cycle.
- FSM states: IDLE -> LOAD -> (SHIFT, decimal only) -> STORE -> LOAD for the next channel, or DONE after the last channel.
  - DONE -> IDLE, or DONE -> LOAD of channel 0 if pending (pending cleared, new snapshot taken).
  - Channels are processed in order 0..CHANNELS-1.
- LOAD (1 cycle): shift register = snapshot value; BCD register (4*DIGITS bits) cleared; overflow computed.
  - Decimal overflow: value > 10^DIGITS-1.
  - Hex overflow: value >= 16^DIGITS; always 0 when IN_WIDTH <= 4*DIGITS.
- SHIFT (decimal only, exactly IN_WIDTH cycles): each cycle, every BCD nibble >= 5 has 3 added, then {bcd, shift} is shifted left by 1 (MSB first).
- STORE (1 cycle): writes the channel's DIGITS codes and its ovf bit; other channels keep their values.
  - Overflow: all digits show dash.
  - Hex mode: digit d = value nibble d (zero-extended).
  - blank_lz=1: zero digits above the most significant nonzero digit are blank; digit 0 is always shown, so value 0 shows "0".
- DONE (1 cycle): busy = 1. busy = 0 in IDLE.
- Per-channel latency: decimal IN_WIDTH+2 cycles, hex 2 cycles.
- Full pass length: CHANNELS × per-channel latency + 1 (DONE).
- Widths: internal BCD math is unsigned with no truncation inside the DIGITS nibbles; the overflow check guards against out-of-range values.

Test Plan:
- Reset: rst_n low mid-SHIFT of channel 1 -> all hex = 7F, busy = 0, ovf = 0 asynchronously; after release, no pass starts until the next trigger.
- Decimal: defaults, in ch0 = 42, ch1 = 7, mode = 0, blank_lz = 0, update pulse -> busy high for 2×8+1 = 17 cycles.
  - ch0 digits 19 ("4"), 24 ("2"); ch1 digits 40 ("0"), 78 ("7").
  - ch0 written on pass cycle 8, ch1 on cycle 16.
- Blanking: same stimulus with blank_lz = 1 -> ch1 tens = 7F, ones = 78; a channel with value 0 shows 7F, 40.
- Overflow and hex: DIGITS = 1, value 63.
  - Decimal: digit 3F, ovf = 1.
  - Hex: ovf = 1 (63 >= 16).
  - DIGITS = 2, hex, value 0x2A: digits 24, 08, ovf = 0, pass = 2×2+1 = 5 cycles.
- Pending: update pulses at pass cycles 2, 5 and 9 -> exactly one extra pass starts right after DONE using in sampled then; busy never drops between the two passes.
- Auto-refresh: REFRESH_DIV = 20, update held 0 -> passes start every 20 cycles; a change to in appears on hex only after the next tick's pass.
